// File: rtl/vec_mul_pkg.sv
// rtl/vec_mul_pkg.sv - shared types and constant helpers for the vector-multiplier datapath
package vec_mul_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  // Working width for the saturation rail helpers; callers truncate to their width
  localparam int SAT_W = 128;

  // Accumulator wide enough that DEPTH full-scale products can never overflow
  function automatic int acc_width_default(input int addr_width, input int data_width);
    return 2 * data_width + addr_width;
  endfunction

  // Largest positive two's-complement value of width w (low w bits are significant)
  function automatic logic [SAT_W-1:0] sat_max(input int w);
    return (SAT_W'(1) << (w - 1)) - SAT_W'(1);
  endfunction

  // Most negative two's-complement value of width w (low w bits are significant)
  function automatic logic [SAT_W-1:0] sat_min(input int w);
    return {SAT_W{1'b1}} << (w - 1);
  endfunction

endpackage

// File: rtl/mac_unit.sv
// rtl/mac_unit.sv - signed multiply with registered accumulate; saturation when DOT_PRODUCT_SAT_EN is defined
module mac_unit
  import vec_mul_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int ACC_WIDTH  = 52
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [ACC_WIDTH-1:0]  acc_next_o
);

  localparam int PW = 2 * DATA_WIDTH;

  logic signed [PW-1:0]        prod;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] sum;
  logic [ACC_WIDTH-1:0]        acc_q;
  logic [ACC_WIDTH-1:0]        acc_d;

  // Full-precision product, then sign-extend or truncate to the accumulator width
  assign prod     = $signed(a_i) * $signed(b_i);
  assign prod_ext = ACC_WIDTH'(prod);

`ifdef DOT_PRODUCT_SAT_EN
  localparam logic [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(sat_max(ACC_WIDTH));
  localparam logic [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(sat_min(ACC_WIDTH));

  logic signed [ACC_WIDTH:0] wide_sum;

  // One guard bit detects overflow; clamp to the rail in the overflow direction
  always_comb begin
    wide_sum = {acc_q[ACC_WIDTH-1], acc_q} + {prod_ext[ACC_WIDTH-1], prod_ext};
    sum      = wide_sum[ACC_WIDTH-1:0];
    if (wide_sum[ACC_WIDTH] != wide_sum[ACC_WIDTH-1]) begin
      sum = wide_sum[ACC_WIDTH] ? SAT_MIN : SAT_MAX;
    end
  end
`else
  // Plain two's-complement wrap
  always_comb begin
    sum = $signed(acc_q) + prod_ext;
  end
`endif

  // Next accumulator value: clear wins over enable
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = sum;
    end
  end

  // Accumulator register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_next_o = acc_d;

endmodule

// File: rtl/dot_product_sequencer.sv
// rtl/dot_product_sequencer.sv - streams A/B RAM addresses, accumulates the dot product, returns it on valid/ready (option DOT_PRODUCT_SAT_EN)
module dot_product_sequencer
  import vec_mul_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 24,
  parameter int ACC_WIDTH  = acc_width_default(ADDR_WIDTH, DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_a_data,
  input  logic [DATA_WIDTH-1:0] ram_b_data,
  output logic [ACC_WIDTH-1:0]  result,
  output logic                  result_valid,
  input  logic                  result_ready
);

  localparam int                DEPTH   = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LEN_MAX = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LEN_ONE = (ADDR_WIDTH + 1)'(1);

  seq_state_e            state_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [ADDR_WIDTH:0]   remaining_q;
  logic                  rd_valid_q;
  logic                  busy_q;
  logic                  err_q;
  logic                  result_valid_q;
  logic [ACC_WIDTH-1:0]  result_q;

  logic                  cmd_legal;
  logic                  cmd_accept;
  logic [ACC_WIDTH-1:0]  acc_next;

  assign cmd_legal  = (length != '0) && (length <= LEN_MAX);
  assign cmd_accept = (state_q == IDLE) && start && cmd_legal;

  // rd_valid_q marks the cycle after an address was issued, when RAM data is on the bus
  mac_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_mac (
    .clk        (clk),
    .rst_n      (reset),
    .clr_i      (cmd_accept),
    .en_i       (rd_valid_q),
    .a_i        (ram_a_data),
    .b_i        (ram_b_data),
    .acc_next_o (acc_next)
  );

  // Sequencer FSM: command capture, address streaming, drain of the last read, result handshake
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      ram_addr_q     <= '0;
      remaining_q    <= '0;
      rd_valid_q     <= 1'b0;
      busy_q         <= 1'b0;
      err_q          <= 1'b0;
      result_valid_q <= 1'b0;
      result_q       <= '0;
    end else begin
      err_q      <= 1'b0;
      rd_valid_q <= (state_q == FETCH);
      case (state_q)
        IDLE: begin
          if (start) begin
            if (cmd_legal) begin
              ram_addr_q  <= base_addr;
              remaining_q <= length;
              busy_q      <= 1'b1;
              state_q     <= FETCH;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (remaining_q == LEN_ONE) begin
            remaining_q <= '0;
            state_q     <= DRAIN;
          end else begin
            remaining_q <= remaining_q - LEN_ONE;
            ram_addr_q  <= ram_addr_q + 1'b1;
          end
        end
        DRAIN: begin
          // The final product lands on this edge, so capture the accumulator's next value
          result_q       <= acc_next;
          result_valid_q <= 1'b1;
          state_q        <= DONE;
        end
        DONE: begin
          if (result_ready) begin
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            state_q        <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign err          = err_q;
  assign ram_addr     = ram_addr_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_dot_product_sequencer.sv
// tb/tb_dot_product_sequencer.sv - randomized self-checking bench for dot_product_sequencer
module tb_dot_product_sequencer;

  localparam int AW   = 4;
  localparam int DW   = 24;
  localparam int ACCW = 2 * DW + AW;
  localparam int SATW = 8;

  logic            clk;
  logic            reset;
  logic            start;
  logic [AW-1:0]   base_addr;
  logic [AW:0]     length;
  logic            result_ready;

  logic            busy, err, result_valid;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_a_data, ram_b_data;
  logic [ACCW-1:0] result;

  logic            busy8, err8, result_valid8;
  logic [AW-1:0]   ram_addr8;
  logic [DW-1:0]   ram_a_data8, ram_b_data8;
  logic [SATW-1:0] result8;

  logic [DW-1:0]   mem_a [16];
  logic [DW-1:0]   mem_b [16];

  int checks;
  int errors;

  dot_product_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .err(err), .ram_addr(ram_addr), .ram_a_data(ram_a_data),
    .ram_b_data(ram_b_data), .result(result), .result_valid(result_valid),
    .result_ready(result_ready)
  );

  dot_product_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ACC_WIDTH(SATW)) dut8 (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy8), .err(err8), .ram_addr(ram_addr8), .ram_a_data(ram_a_data8),
    .ram_b_data(ram_b_data8), .result(result8), .result_valid(result_valid8),
    .result_ready(result_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read RAMs, one cycle of latency
  always @(posedge clk) begin
    ram_a_data  <= mem_a[ram_addr];
    ram_b_data  <= mem_b[ram_addr];
    ram_a_data8 <= mem_a[ram_addr8];
    ram_b_data8 <= mem_b[ram_addr8];
  end

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint wrapw(input longint v, input int w);
    return (v <<< (64 - w)) >>> (64 - w);
  endfunction

  // Reference dot product over the circular vector window, at accumulator width w
  function automatic longint model_dot(input int base, input int len, input int w);
    longint acc, p, hi, lo;
    int idx;
    acc = 0;
    hi  = (64'sd1 <<< (w - 1)) - 1;
    lo  = -hi - 1;
    for (int i = 0; i < len; i++) begin
      idx = (base + i) % 16;
      p   = wrapw(longint'($signed(mem_a[idx])) * longint'($signed(mem_b[idx])), w);
      acc = acc + p;
`ifdef DOT_PRODUCT_SAT_EN
      if (acc > hi) acc = hi;
      if (acc < lo) acc = lo;
`else
      acc = wrapw(acc, w);
`endif
    end
    return acc;
  endfunction

  task automatic run_cmd(input int base, input int len, input int hold);
    longint exp, exp8;
    exp  = model_dot(base, len, ACCW);
    exp8 = model_dot(base, len, SATW);
    @(negedge clk);
    start     = 1'b1;
    base_addr = base[AW-1:0];
    length    = len[AW:0];
    @(negedge clk);
    start     = 1'b0;
    base_addr = AW'($urandom);
    length    = (AW + 1)'($urandom);
    for (int c = 1; c <= len; c++) begin
      check("addr", longint'(ram_addr), longint'((base + c - 1) % 16));
      check("busy_fetch", longint'(busy), 1);
      @(negedge clk);
    end
    check("early_valid", longint'(result_valid), 0);
    @(negedge clk);
    check("valid", longint'(result_valid), 1);
    check("result", longint'($signed(result)), exp);
    check("result8", longint'($signed(result8)), exp8);
    for (int k = 0; k < hold; k++) begin
      start     = 1'($urandom);
      base_addr = AW'($urandom);
      length    = (AW + 1)'($urandom);
      @(negedge clk);
      check("hold_result", longint'($signed(result)), exp);
      check("hold_valid", longint'(result_valid), 1);
      check("hold_err", longint'(err), 0);
    end
    result_ready = 1'b1;
    start        = 1'b1;
    length       = 5'd3;
    @(negedge clk);
    result_ready = 1'b0;
    start        = 1'b0;
    check("hs_valid", longint'(result_valid), 0);
    check("hs_busy", longint'(busy), 0);
    check("hs_keep", longint'($signed(result)), exp);
    @(negedge clk);
    check("idle_busy", longint'(busy), 0);
  endtask

  task automatic err_cmd(input int len);
    @(negedge clk);
    start  = 1'b1;
    length = len[AW:0];
    @(negedge clk);
    start = 1'b0;
    check("err_pulse", longint'(err), 1);
    check("err_busy", longint'(busy), 0);
    @(negedge clk);
    check("err_clear", longint'(err), 0);
    check("err_valid", longint'(result_valid), 0);
    check("err_busy2", longint'(busy), 0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = DW'($urandom);
      mem_b[i] = DW'($urandom);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b0;
    start        = 1'b0;
    base_addr    = '0;
    length       = '0;
    result_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    repeat (3) @(negedge clk);
    check("rst_busy", longint'(busy), 0);
    check("rst_err", longint'(err), 0);
    check("rst_addr", longint'(ram_addr), 0);
    check("rst_result", longint'(result), 0);
    check("rst_valid", longint'(result_valid), 0);
    reset = 1'b1;

    // Small integer vectors
    mem_a[0] = 24'd1; mem_a[1] = 24'd2; mem_a[2] = 24'd3;
    mem_b[0] = 24'd4; mem_b[1] = 24'd5; mem_b[2] = 24'd6;
    check("model_32", model_dot(0, 3, ACCW), 32);
    run_cmd(0, 3, 0);

    // Single negative element
    mem_a[7] = -24'sd3;
    mem_b[7] = 24'd7;
    run_cmd(7, 1, 2);
    check("neg21", longint'($signed(result)), -21);

    // Address wrap
    mem_a[14] = 24'd1; mem_a[15] = 24'd1; mem_a[0] = 24'd1; mem_a[1] = 24'd1;
    mem_b[14] = 24'd1; mem_b[15] = 24'd1; mem_b[0] = 24'd1; mem_b[1] = 24'd1;
    run_cmd(14, 4, 0);
    check("wrap4", longint'($signed(result)), 4);

    // Illegal lengths
    err_cmd(0);
    err_cmd(17);

    // Back-pressure with start pulsing
    fill_random();
    run_cmd(5, 6, 10);

    // Saturation vs wrap on the narrow accumulator
    mem_a[0] = 24'd100; mem_a[1] = 24'd100;
    mem_b[0] = 24'd1;   mem_b[1] = 24'd1;
    run_cmd(0, 2, 0);
`ifdef DOT_PRODUCT_SAT_EN
    check("sat8", longint'($signed(result8)), 127);
`else
    check("wrap8", longint'($signed(result8)), -56);
`endif
    check("wide200", longint'($signed(result)), 200);

    // Reset mid-FETCH
    fill_random();
    @(negedge clk);
    start     = 1'b1;
    base_addr = 4'd3;
    length    = 5'd8;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_busy", longint'(busy), 0);
    check("abort_addr", longint'(ram_addr), 0);
    check("abort_result", longint'(result), 0);
    check("abort_valid", longint'(result_valid), 0);
    @(negedge clk);
    reset = 1'b1;
    run_cmd(3, 8, 1);

    // Randomized commands, full 1..16 lengths
    for (int t = 0; t < 20; t++) begin
      fill_random();
      run_cmd(int'($urandom_range(0, 15)), int'($urandom_range(1, 16)),
              int'($urandom_range(0, 3)));
    end
    fill_random();
    run_cmd(int'($urandom_range(0, 15)), 16, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dot_product_sequencer.md
Name: dot_product_sequencer

Overview:
Controller that sequences a pair of block_ram instances holding vectors A and B. It streams addresses over a shared read-address bus and multiply-accumulates the returned words. It then presents the signed dot product on a valid/ready result port. It sits between the host/command logic and the vector RAMs in the vector-multiplier datapath. The parent ties both RAMs' write_enable low while this block is busy.

Parameters:
ADDR_WIDTH, 4, vector RAM address width; DEPTH = 2**ADDR_WIDTH
DATA_WIDTH, 24, signed element width of A and B
ACC_WIDTH, 2*DATA_WIDTH+ADDR_WIDTH, accumulator/result width; may be set smaller (see saturation feature)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  command strobe, sampled only in IDLE
base_addr  in  ADDR_WIDTH  first element address
length  in  ADDR_WIDTH+1  element count, legal 1..DEPTH
busy  out  1  high whenever state != IDLE
err  out  1  one-cycle pulse on a rejected command
ram_addr  out  ADDR_WIDTH  shared read address to A and B RAMs (registered)
ram_a_data  in  DATA_WIDTH  A RAM data_out
ram_b_data  in  DATA_WIDTH  B RAM data_out
result  out  ACC_WIDTH  signed dot product
result_valid  out  1  result handshake valid
result_ready  in  1  result handshake ready

Behaviour:
- Reset (reset low, async): state=IDLE; busy, err, result_valid, ram_addr, result, acc and counters all 0.
- RAM model: registered read, 1-cycle latency. An address presented in cycle n yields data in cycle n+1.
- FSM states: IDLE, FETCH, DRAIN, DONE.
- IDLE, start=1, legal length at edge 0:
  - load ram_addr=base_addr, remaining=length, acc=0; go to FETCH.
- IDLE, start=1, length=0 or length>DEPTH:
  - err=1 for exactly one cycle; stay IDLE; no RAM access.
- FETCH, cycles 1..L:
  - ram_addr = base_addr+i, i=0..L-1, incrementing modulo DEPTH (wraps 15->0 at defaults).
  - After the address for element L-1 is issued, go to DRAIN.
- Accumulation: at every edge from edge 2 through edge L+1:
  - acc += sext(ram_a_data) * sext(ram_b_data), signed.
  - The product is 2*DATA_WIDTH bits, sign-extended or truncated to ACC_WIDTH.
  - Without saturation, wrap is modulo 2^ACC_WIDTH.
- DRAIN, cycle L+1: final product accumulated at edge L+1; go to DONE.
- DONE, from cycle L+2:
  - result_valid=1; result=acc, held stable until handshake.
  - result_valid&&result_ready at an edge: result_valid=0 and state=IDLE on that edge. result keeps its last value.
- Latency: start edge to first result_valid cycle = L+2 cycles. L=1 gives 3 cycles; L=16 gives 18 cycles.
- start while busy (including in the handshake cycle) is ignored, with no err.
- Inputs base_addr/length are captured at the start edge; later changes have no effect.
- Reset mid-operation aborts immediately to the reset values; any in-flight RAM data is discarded.

Optional Feature:
- Macro: DOT_PRODUCT_SAT_EN.
- Defined: each accumulate saturates to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]. Once saturated, acc stays clamped while further terms push the same direction, and moves off the rail for opposite-sign terms.
- Undefined: two's-complement wrap modulo 2^ACC_WIDTH.

Decomposition:
- Package vec_mul_pkg: FSM state enum (IDLE/FETCH/DRAIN/DONE), a default ACC_WIDTH helper function, and the SAT min/max constant helpers.
- Sub-module mac_unit: combinational signed multiply plus registered accumulate with clear, enable, and the optional saturation. The FSM, address counter and handshake stay in the top level.

Test Plan:
- A=[1,2,3], B=[4,5,6], base=0, length=3: ram_addr 0,1,2 in cycles 1-3; result_valid from cycle 5; result=32.
- A[7]=-3, B[7]=7, base=7, length=1: result_valid in cycle 3; result=-21, sign-extended to ACC_WIDTH.
- base=14, length=4, A=B=[1,1,1,1] at 14,15,0,1: ram_addr sequence 14,15,0,1 (wrap); result=4.
- length=0, then length=17 (at defaults): err pulses one cycle each; busy stays 0; result_valid never asserts.
- Back-pressure: hold result_ready=0 for 10 cycles with start pulsing: result stable, no new command accepted. Raise result_ready: handshake returns to IDLE, busy=0 the next cycle.
- Reset low mid-FETCH (length=8, at cycle 4): all outputs 0 immediately; a new command after release gives a correct fresh result.
- Saturation, ACC_WIDTH=8, A=[100,100], B=[1,1]: with DOT_PRODUCT_SAT_EN result=127; without it result=-56.
